// File: rtl/store_unit_pkg.sv
// store_unit_pkg: shared store-op encodings and store_unit FSM states.
//   STORE_OP_WIDTH / STORE_OP_SB/SH/SW : store decoder output encoding
//   store_state_e                      : store_unit control states
package store_unit_pkg;

  localparam int unsigned STORE_OP_WIDTH = 2;

  localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SB = 2'b00;
  localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SH = 2'b01;
  localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SW = 2'b10;

  localparam int unsigned STORE_UNIT_STATE_WIDTH = 2;

  typedef enum logic [STORE_UNIT_STATE_WIDTH-1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    FAULT = 2'b10
  } store_state_e;

endpackage

// File: rtl/store_align.sv
// store_align: combinational lane alignment for stores.
//   i_op      : STOREop (SB/SH/SW)
//   i_addr_lo : byte offset addr[1:0]
//   i_wdata   : rs2 value
//   o_wdata   : lane-replicated write data
//   o_wmask   : byte strobes
//   o_fault   : misaligned access or illegal op
module store_align
  import store_unit_pkg::*;
(
  input  logic [STORE_OP_WIDTH-1:0] i_op,
  input  logic [1:0]                i_addr_lo,
  input  logic [31:0]               i_wdata,
  output logic [31:0]               o_wdata,
  output logic [3:0]                o_wmask,
  output logic                      o_fault
);

  always_comb begin
    o_wdata = i_wdata;
    o_wmask = '0;
    o_fault = 1'b0;
    case (i_op)
      STORE_OP_SB: begin
        o_wdata = {4{i_wdata[7:0]}};
        o_wmask = 4'b0001 << i_addr_lo;
      end
      STORE_OP_SH: begin
        o_wdata = {2{i_wdata[15:0]}};
        o_wmask = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_fault = i_addr_lo[0];
      end
      STORE_OP_SW: begin
        o_wmask = '1;
        o_fault = (i_addr_lo != 2'b00);
      end
      default: o_fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// store_unit: store execution stage. Accepts a store on start, aligns it,
// issues one valid/ready write on the data bus and reports the outcome.
//   clk, rst (sync, active-high)
//   start, STOREop, addr, wdata_in : request from the control FSM
//   busy, done, misaligned, bus_error : status back to the control FSM
//   mem_valid, mem_addr, mem_wdata, mem_wmask, mem_ready : data bus
// All outputs come straight from flops.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT   = 0,
  parameter int unsigned TIMEOUT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [STORE_OP_WIDTH-1:0] STOREop,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata_in,
  output logic                      busy,
  output logic                      done,
  output logic                      misaligned,
  output logic                      bus_error,
  output logic                      mem_valid,
  output logic [31:0]               mem_addr,
  output logic [31:0]               mem_wdata,
  output logic [3:0]                mem_wmask,
  input  logic                      mem_ready
);

  localparam logic [TIMEOUT_WIDTH-1:0] LP_LAST =
    TIMEOUT_WIDTH'((BUS_TIMEOUT == 0) ? 0 : BUS_TIMEOUT - 1);

  store_state_e             r_state, w_state_nxt;
  logic                     r_busy, r_done, r_mis, r_berr, r_valid;
  logic [31:0]              r_addr, r_wdata;
  logic [3:0]               r_wmask;
  logic [TIMEOUT_WIDTH-1:0] r_cnt;

  logic                     w_done_nxt, w_mis_nxt, w_berr_nxt, w_valid_nxt;
  logic [31:0]              w_addr_nxt, w_wdata_nxt;
  logic [3:0]               w_wmask_nxt;
  logic [TIMEOUT_WIDTH-1:0] w_cnt_nxt;

  logic [31:0]              w_al_wdata;
  logic [3:0]               w_al_wmask;
  logic                     w_al_fault;

  store_align u_align (
    .i_op      (STOREop),
    .i_addr_lo (addr[1:0]),
    .i_wdata   (wdata_in),
    .o_wdata   (w_al_wdata),
    .o_wmask   (w_al_wmask),
    .o_fault   (w_al_fault)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mis   <= 1'b0;
      r_berr  <= 1'b0;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= w_done_nxt;
      r_mis   <= w_mis_nxt;
      r_berr  <= w_berr_nxt;
      r_valid <= w_valid_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_wmask <= w_wmask_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Status pulses are computed one state ahead so they appear registered
  // in the cycle the FSM enters IDLE (done/bus_error) or FAULT (misaligned).
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_mis_nxt   = 1'b0;
    w_berr_nxt  = 1'b0;
    w_valid_nxt = r_valid;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_wmask_nxt = r_wmask;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_addr_nxt  = {addr[31:2], 2'b00};
          w_wdata_nxt = w_al_wdata;
          w_wmask_nxt = w_al_wmask;
          if (w_al_fault) begin
            w_state_nxt = FAULT;
            w_mis_nxt   = 1'b1;
          end else begin
            w_state_nxt = REQ;
            w_valid_nxt = 1'b1;
            w_cnt_nxt   = '0;
          end
        end
      end
      REQ: begin
        if (mem_ready) begin
          w_state_nxt = IDLE;
          w_valid_nxt = 1'b0;
          w_done_nxt  = 1'b1;
        end else if ((BUS_TIMEOUT != 0) && (r_cnt == LP_LAST)) begin
          w_state_nxt = IDLE;
          w_valid_nxt = 1'b0;
          w_berr_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + TIMEOUT_WIDTH'(1);
        end
      end
      FAULT:   w_state_nxt = IDLE;
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign misaligned = r_mis;
  assign bus_error  = r_berr;
  assign mem_valid  = r_valid;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_wmask  = r_wmask;

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Store execution stage directly downstream of store_decoder in the kianv harris multicycle rv32im core.
- Accepts STOREop, effective address and rs2 data from the control FSM on a start pulse, then performs lane alignment, byte-mask generation and misalignment checking.
- Issues one registered valid/ready write on the data-memory bus and reports completion or a fault back to the control FSM.
- AMO stores reach this block already resolved to STORE_OP_SW by the decoder; no special handling here.

Parameters:
- BUS_TIMEOUT, 0, maximum number of REQ cycles spent waiting for mem_ready before aborting with bus_error; 0 disables the timeout.
- TIMEOUT_WIDTH, 16, width of the wait counter; BUS_TIMEOUT must be below 2**TIMEOUT_WIDTH.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request from the control FSM; sampled only in IDLE.
- STOREop  input  STORE_OP_WIDTH  store decoder output (SB/SH/SW).
- addr  input  32  effective byte address.
- wdata_in  input  32  rs2 value.
- busy  output  1  high in every non-IDLE state.
- done  output  1  one-cycle pulse when the write is accepted.
- misaligned  output  1  one-cycle pulse on an alignment fault or an illegal STOREop; no bus access occurs.
- bus_error  output  1  one-cycle pulse on timeout abort.
- mem_valid  output  1  write request.
- mem_addr  output  32  word address {addr[31:2],2'b00}.
- mem_wdata  output  32  lane-replicated write data.
- mem_wmask  output  4  byte strobes.
- mem_ready  input  1  slave accepts the write in the cycle where mem_valid & mem_ready.

Behaviour:
- Reset: state IDLE. busy, done, misaligned, bus_error and mem_valid are 0. mem_addr, mem_wdata, mem_wmask and the wait counter are 0.
- All outputs are registered; no combinational path runs from an input to an output.
- Data formatting:
  - SB: wdata = {4{wdata_in[7:0]}}, wmask = 4'b0001 << addr[1:0].
  - SH: wdata = {2{wdata_in[15:0]}}, wmask = 4'b0011 << {addr[1],1'b0}.
  - SW: wdata = wdata_in, wmask = 4'b1111.
- Fault conditions:
  - SH with addr[0]=1.
  - SW with addr[1:0]!=0.
  - Any STOREop value other than SB, SH or SW.
- States and transitions:
  - IDLE: on start, latch mem_addr, mem_wdata and mem_wmask. If a fault condition holds, go to FAULT; otherwise go to REQ with mem_valid=1 and the counter cleared. With start low, remain in IDLE.
  - REQ: mem_valid stays high; address, data and mask stay stable until accepted.
    - If mem_ready: next cycle go to IDLE with mem_valid=0 and done=1 for that single cycle.
    - Else if BUS_TIMEOUT!=0 and counter==BUS_TIMEOUT-1: next cycle go to IDLE with mem_valid=0 and bus_error=1.
    - Otherwise increment the counter.
    - If mem_ready and the timeout land in the same cycle, mem_ready wins.
  - FAULT: misaligned=1 for exactly one cycle, then IDLE. mem_valid never rises.
- Latency: start at cycle N gives mem_valid from cycle N+1. If mem_ready is high at N+1, done=1 at N+2. A faulting store pulses misaligned at N+1.
- done, misaligned and bus_error are mutually exclusive and each lasts one cycle.
- start while busy is ignored, with no queueing. start in the same cycle as done is accepted, because the FSM is back in IDLE in that cycle.
- mem_ready outside REQ is ignored.
- rst mid-REQ: mem_valid drops at the next edge and no done is produced. The bus slave must tolerate an abandoned request.
- rst has priority over start.

Decomposition:
- STORE_OP_WIDTH and STORE_OP_SB/SH/SW come from the shared riscv_defines.vh; add no local copies.
- Add a shared `STORE_UNIT_STATE_WIDTH plus IDLE/REQ/FAULT encodings to riscv_defines.vh.
- One natural sub-module: store_align, purely combinational. It maps STOREop, addr[1:0] and wdata_in to wdata, wmask and a fault flag. The FSM, registers and timeout counter stay in store_unit.

Test Plan:
- SB, addr=0x1003, wdata_in=0xDEADBEEF, mem_ready high at first REQ cycle -> mem_addr=0x1000, mem_wdata=0xEFEFEFEF, mem_wmask=4'b1000; done at start+2; busy low afterwards.
- SH, addr=0x2002, wdata_in=0x1234ABCD, mem_ready held low 3 cycles -> mem_wdata=0xABCDABCD, mem_wmask=4'b1100; mem_valid and data stable for 4 cycles; done one cycle after acceptance.
- SW addr=0x3001, SH addr=0x3003, and an illegal STOREop -> each gives misaligned for exactly 1 cycle and mem_valid never asserts.
- BUS_TIMEOUT=4, mem_ready tied low -> mem_valid high for exactly 4 cycles, bus_error pulses once, done never asserts; a repeat run with mem_ready rising in the 4th REQ cycle must give done, not bus_error.
- Second start pulse while in REQ -> ignored, exactly one bus transfer; start issued in the done cycle -> a new REQ begins the following cycle.
- rst asserted in the 2nd REQ cycle -> all outputs return to reset values at the next edge, no done; the next store after reset completes normally.
